// File: rtl/branch_resolve_ctrl_if.sv
// Fetch/execute/recovery/training signal bundle for branch_resolve_ctrl.
// master = pipeline side, slave = resolve controller.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface branch_resolve_ctrl_if #(
  parameter int WORD_SIZE = `WORD_SIZE
);
  logic                 fetch_valid;
  logic [WORD_SIZE-1:0] fetch_pc;
  logic                 fetch_pred_taken;
  logic [WORD_SIZE-1:0] fetch_pred_target;
  logic                 fetch_ready;
  logic                 ex_valid;
  logic [WORD_SIZE-1:0] ex_pc;
  logic                 ex_is_branch;
  logic                 ex_taken;
  logic [WORD_SIZE-1:0] ex_target;
  logic                 flush;
  logic                 redirect_valid;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 upd_valid;
  logic [WORD_SIZE-1:0] upd_pc;
  logic [WORD_SIZE-1:0] upd_target;
  logic                 upd_taken;
  logic                 sync_err;

  modport master (
    output fetch_valid, fetch_pc,
    output fetch_pred_taken, fetch_pred_target,
    output ex_valid, ex_pc, ex_is_branch,
    output ex_taken, ex_target,
    input  fetch_ready, flush,
    input  redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_target,
    input  upd_taken, sync_err
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    input  fetch_pred_taken, fetch_pred_target,
    input  ex_valid, ex_pc, ex_is_branch,
    input  ex_taken, ex_target,
    output fetch_ready, flush,
    output redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_target,
    output upd_taken, sync_err
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution, mispredict recovery and predictor training.
// Optional counters via `define BR_RESOLVE_STATS_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module branch_resolve_ctrl #(
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2
) (
  input  logic clk,
  input  logic rst,
  branch_resolve_ctrl_if.slave bus
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REFILL
  } state_e;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  state_e state_q, state_d;

  logic [WORD_SIZE-1:0] pc_q  [DEPTH];
  logic [WORD_SIZE-1:0] tgt_q [DEPTH];
  logic [DEPTH-1:0]     pt_q;

  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0]   cnt_q;

  logic                 sync_err_q;
  logic [WORD_SIZE-1:0] redir_q;
  logic                 upd_v_q;
  logic                 upd_t_q;
  logic [WORD_SIZE-1:0] upd_pc_q;
  logic [WORD_SIZE-1:0] upd_tgt_q;

  logic                 fetch_rdy;
  logic                 pop_req;
  logic                 do_pop;
  logic                 do_push;
  logic                 pc_bad;
  logic                 mis;
  logic                 hd_pt;
  logic [WORD_SIZE-1:0] hd_pc;
  logic [WORD_SIZE-1:0] hd_tgt;
  logic [WORD_SIZE-1:0] corr_pc;

  always_comb begin
    fetch_rdy = (cnt_q < FULL) && (state_q != FLUSH);
    pop_req   = bus.ex_valid && (state_q == IDLE);
    do_pop    = pop_req && (cnt_q != '0);
    // a pop frees a slot, so a full FIFO can still take a push
    do_push   = bus.fetch_valid && (state_q != FLUSH)
                && ((cnt_q != FULL) || do_pop);
    hd_pc     = pc_q[rd_q];
    hd_tgt    = tgt_q[rd_q];
    hd_pt     = pt_q[rd_q];
    pc_bad    = do_pop && (hd_pc != bus.ex_pc);
    mis = do_pop && (pc_bad
          || (bus.ex_is_branch && (bus.ex_taken != hd_pt))
          || (bus.ex_is_branch && bus.ex_taken && hd_pt
              && (bus.ex_target != hd_tgt))
          || (!bus.ex_is_branch && hd_pt));
    corr_pc = (bus.ex_is_branch && bus.ex_taken)
              ? bus.ex_target
              : bus.ex_pc + WORD_SIZE'(4);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mis) state_d = FLUSH;
      FLUSH:   state_d = REFILL;
      REFILL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_q[wr_q]  <= bus.fetch_pc;
      tgt_q[wr_q] <= bus.fetch_pred_target;
      pt_q[wr_q]  <= bus.fetch_pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
      redir_q    <= '0;
      upd_v_q    <= 1'b0;
      upd_t_q    <= 1'b0;
      upd_pc_q   <= '0;
      upd_tgt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FLUSH) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (do_push) wr_q <= wr_q + 1'b1;
        if (do_pop)  rd_q <= rd_q + 1'b1;
        if (do_push && !do_pop) cnt_q <= cnt_q + 1'b1;
        if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
      end
      if ((pop_req && cnt_q == '0) || pc_bad)
        sync_err_q <= 1'b1;
      if (mis) redir_q <= corr_pc;
      upd_v_q <= do_pop && bus.ex_is_branch;
      if (do_pop && bus.ex_is_branch) begin
        upd_pc_q  <= bus.ex_pc;
        upd_t_q   <= bus.ex_taken;
        upd_tgt_q <= bus.ex_target;
      end
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] st_br_q, st_mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_br_q  <= '0;
      st_mis_q <= '0;
    end else begin
      if (do_pop && bus.ex_is_branch && st_br_q != '1)
        st_br_q <= st_br_q + 1'b1;
      if (mis && st_mis_q != '1)
        st_mis_q <= st_mis_q + 1'b1;
    end
  end

  assign stat_branches    = st_br_q;
  assign stat_mispredicts = st_mis_q;
`endif

  assign bus.fetch_ready    = fetch_rdy;
  assign bus.flush          = (state_q == FLUSH);
  assign bus.redirect_valid = (state_q == FLUSH);
  assign bus.redirect_pc    = redir_q;
  assign bus.upd_valid      = upd_v_q;
  assign bus.upd_pc         = upd_pc_q;
  assign bus.upd_target     = upd_tgt_q;
  assign bus.upd_taken      = upd_t_q;
  assign bus.sync_err       = sync_err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed + random bench for branch_resolve_ctrl against a
// queue-based reference model.
module tb_branch_resolve_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.WORD_SIZE(32)) bus ();

`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] stat_b, stat_m;
  branch_resolve_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .stat_branches(stat_b), .stat_mispredicts(stat_m)
  );
`else
  branch_resolve_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tg;
  } rec_t;

  rec_t q[$];
  int   recov;
  logic m_serr;
  logic [31:0] m_rpc;
  logic m_uv, m_ut;
  logic [31:0] m_upc, m_utg;
  logic [31:0] m_sb, m_sm;

  int total = 0;
  int bad   = 0;

  logic        fv, fpt, ev, eb, et;
  logic [31:0] fpc, ftg, epc, etg;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    recov  = 0;
    m_serr = 1'b0;
    m_rpc  = '0;
    m_uv   = 1'b0;
    m_ut   = 1'b0;
    m_upc  = '0;
    m_utg  = '0;
    m_sb   = '0;
    m_sm   = '0;
  endtask

  task automatic model_step();
    bit pop, push, mis;
    rec_t h;
    if (rst) begin
      model_reset();
      return;
    end
    pop  = ev && recov == 0 && q.size() > 0;
    push = fv && recov != 2 && (q.size() < 4 || pop);
    mis  = 0;
    if (ev && recov == 0 && q.size() == 0) m_serr = 1'b1;
    m_uv = pop && eb;
    if (pop) begin
      h = q.pop_front();
      if (h.pc != epc) begin
        m_serr = 1'b1;
        mis = 1;
      end
      if (eb && et != h.pt) mis = 1;
      if (eb && et && h.pt && etg != h.tg) mis = 1;
      if (!eb && h.pt) mis = 1;
      if (mis) m_rpc = (eb && et) ? etg : epc + 32'd4;
      if (eb) begin
        m_upc = epc;
        m_ut  = et;
        m_utg = etg;
        if (m_sb != 32'hFFFF_FFFF) m_sb++;
      end
      if (mis && m_sm != 32'hFFFF_FFFF) m_sm++;
    end
    if (push) q.push_back('{pc: fpc, pt: fpt, tg: ftg});
    if (recov == 2) q.delete();
    if (recov > 0) recov--;
    else if (mis) recov = 2;
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".rdy"}, 32'(bus.fetch_ready),
        32'(q.size() < 4 && recov != 2));
    chk({tag, ".flush"}, 32'(bus.flush), 32'(recov == 2));
    chk({tag, ".rv"}, 32'(bus.redirect_valid), 32'(recov == 2));
    chk({tag, ".rpc"}, bus.redirect_pc, m_rpc);
    chk({tag, ".serr"}, 32'(bus.sync_err), 32'(m_serr));
    chk({tag, ".uv"}, 32'(bus.upd_valid), 32'(m_uv));
    chk({tag, ".upc"}, bus.upd_pc, m_upc);
    chk({tag, ".ut"}, 32'(bus.upd_taken), 32'(m_ut));
    chk({tag, ".utg"}, bus.upd_target, m_utg);
`ifdef BR_RESOLVE_STATS_EN
    chk({tag, ".sb"}, stat_b, m_sb);
    chk({tag, ".sm"}, stat_m, m_sm);
`endif
  endtask

  task automatic idle();
    fv = 0; fpc = '0; fpt = 0; ftg = '0;
    ev = 0; epc = '0; eb = 0; et = 0; etg = '0;
  endtask

  task automatic push(logic [31:0] p, logic t, logic [31:0] g);
    fv = 1; fpc = p; fpt = t; ftg = g;
  endtask

  task automatic pop(logic [31:0] p, logic b, logic t,
                     logic [31:0] g);
    ev = 1; epc = p; eb = b; et = t; etg = g;
  endtask

  always_comb begin
    bus.fetch_valid       = fv;
    bus.fetch_pc          = fpc;
    bus.fetch_pred_taken  = fpt;
    bus.fetch_pred_target = ftg;
    bus.ex_valid          = ev;
    bus.ex_pc             = epc;
    bus.ex_is_branch      = eb;
    bus.ex_taken          = et;
    bus.ex_target         = etg;
  end

  initial begin
    model_reset();
    idle();
    rst = 1;
    tick("reset0");
    tick("reset1");
    rst = 0;
    tick("idle");

    push(32'h10, 1, 32'h40);                tick("ok.push");
    idle(); pop(32'h10, 1, 1, 32'h40);       tick("ok.pop");
    idle();                                  tick("ok.after");

    push(32'h20, 0, 32'h24);                 tick("nt.push");
    idle(); pop(32'h20, 1, 1, 32'h80);       tick("nt.pop");
    idle();                                  tick("nt.flush");
    chk("nt.redir80", bus.redirect_pc, 32'h80);
    tick("nt.refill");
    tick("nt.idle");

    push(32'h30, 1, 32'h50);                 tick("al.push");
    idle(); pop(32'h30, 0, 0, 32'h0);        tick("al.pop");
    idle();                                  tick("al.flush");
    chk("al.redir34", bus.redirect_pc, 32'h34);
    tick("al.refill");
    tick("al.idle");

    for (int i = 0; i < 4; i++) begin
      push(32'h100 + 32'(i * 4), 0, 32'h0);  tick("full.fill");
    end
    idle();                                  tick("full.hold");
    for (int i = 0; i < 10; i++) begin
      push(32'h200 + 32'(i * 4), 0, 32'h0);
      pop(q[0].pc, 1, 0, 32'h0);             tick("full.pp");
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      pop(q[0].pc, 0, 0, 32'h0);             tick("full.drain");
    end
    idle();                                  tick("full.empty");

    pop(32'h999, 1, 1, 32'h0);               tick("emp.pop");
    idle();                                  tick("emp.after");
    chk("emp.serr", 32'(bus.sync_err), 32'd1);
    tick("emp.stick");

    push(32'h40, 0, 32'h44);                 tick("rf.push");
    idle(); pop(32'h40, 1, 1, 32'hA0);       tick("rf.pop");
    idle(); rst = 1;                         tick("rf.rst");
    rst = 0;                                 tick("rf.idle");

    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(99) == 0);
      if ($urandom_range(1) == 1)
        push(32'($urandom_range(15)) << 2,
             1'($urandom_range(1)),
             32'($urandom_range(3)) << 4);
      if ($urandom_range(2) != 0) begin
        pop(q.size() > 0 ? q[0].pc : 32'h8,
            1'($urandom_range(1)), 1'($urandom_range(1)),
            32'($urandom_range(3)) << 4);
        if ($urandom_range(15) == 0) epc = epc ^ 32'h4;
      end
      tick("rnd");
    end
    rst = 0;
    idle();
    tick("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
